// File: rtl/can_defs.sv
// Shared definitions for the CAN bit stuffer: FSM encoding, stuff run length
// and a saturating counter helper.
package can_defs;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS  = 2'd1,
        S_STUFF = 2'd2,
        S_TAIL  = 2'd3
    } stuff_state_e;

    localparam logic [2:0] STUFF_RUN_LEN = 3'd5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/can_bit_monitor.sv
// Readback monitor: compares the driven bit with the bus level at each sample
// point and classifies any difference as lost arbitration, ACK or bit error.
module can_bit_monitor (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sample_point_i,
    input  logic active_i,
    input  logic tx_bit_i,
    input  logic rx_bit_i,
    input  logic arb_i,
    input  logic ack_slot_i,
    output logic abort_o,
    output logic arb_lost_o,
    output logic bit_error_o,
    output logic ack_seen_o
);

    logic mism, rec_lost, arb_c, ack_c, err_c;
    logic arb_lost_q, bit_error_q, ack_seen_q;

    always_comb begin
        mism     = active_i & (tx_bit_i ^ rx_bit_i);
        // Recessive driven but dominant read: the only case arbitration/ACK excuse.
        rec_lost = mism & tx_bit_i;
        arb_c    = rec_lost & arb_i;
        ack_c    = rec_lost & ~arb_i & ack_slot_i;
        err_c    = mism & ~arb_c & ~ack_c;
        abort_o  = sample_point_i & (arb_c | err_c);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            arb_lost_q  <= 1'b0;
            bit_error_q <= 1'b0;
            ack_seen_q  <= 1'b0;
        end else begin
            arb_lost_q  <= sample_point_i & arb_c;
            bit_error_q <= sample_point_i & err_c;
            ack_seen_q  <= sample_point_i & ack_c;
        end
    end

    assign arb_lost_o  = arb_lost_q;
    assign bit_error_o = bit_error_q;
    assign ack_seen_o  = ack_seen_q;

endmodule

// File: rtl/can_bit_stuffer.sv
// CAN transmit bit stuffer: inserts a complement bit after five equal bits in
// the stuffing region, stalls the transmitter for that bit time, and aborts on
// readback errors reported by the bit monitor.
module can_bit_stuffer
    import can_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_point,
    input  logic       frame_active,
    input  logic       stuff_en,
    input  logic       in_bit,
    input  logic       arbitration_active,
    input  logic       ack_slot,
    input  logic       rx_bit,
    output logic       tx_bit_stuffed,
    output logic       stall,
    output logic       stuff_inserted,
    output logic       arb_lost,
    output logic       bit_error,
    output logic       ack_seen,
    output logic [7:0] stuff_total
);

    stuff_state_e state_q, state_d;
    logic         tx_q, tx_d;
    logic         last_q, last_d;
    logic [2:0]   run_q, run_d, run_nxt;
    logic [7:0]   total_q, total_d;
    logic         stuff_q, stuff_d;
    logic         abort;

    can_bit_monitor u_mon (
        .clk_i          (clk),
        .rst_i          (rst),
        .sample_point_i (sample_point),
        .active_i       (state_q != S_IDLE),
        .tx_bit_i       (tx_q),
        .rx_bit_i       (rx_bit),
        .arb_i          (arbitration_active),
        .ack_slot_i     (ack_slot),
        .abort_o        (abort),
        .arb_lost_o     (arb_lost),
        .bit_error_o    (bit_error),
        .ack_seen_o     (ack_seen)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        last_d  = last_q;
        run_d   = run_q;
        total_d = total_q;
        stuff_d = 1'b0;
        run_nxt = (in_bit == last_q) ? run_q + 3'd1 : 3'd1;
        if (sample_point) begin
            // A readback failure wins over anything the stuffing logic wants to do.
            if (abort) begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_d = 1'b1;
                        if (frame_active) begin
                            tx_d    = in_bit;
                            last_d  = in_bit;
                            run_d   = 3'd1;
                            total_d = 8'd0;
                            state_d = S_PASS;
                        end
                    end
                    S_PASS: begin
                        if (!frame_active) begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            tx_d = in_bit;
                            if (!stuff_en) begin
                                state_d = S_TAIL;
                            end else begin
                                run_d  = run_nxt;
                                last_d = in_bit;
                                if (run_nxt == STUFF_RUN_LEN)
                                    state_d = S_STUFF;
                            end
                        end
                    end
                    S_STUFF: begin
                        // The stuff bit opens the next run.
                        tx_d    = ~last_q;
                        last_d  = ~last_q;
                        run_d   = 3'd1;
                        stuff_d = 1'b1;
                        total_d = sat_inc8(total_q);
                        state_d = S_PASS;
                    end
                    S_TAIL: begin
                        if (!frame_active) begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            tx_d = in_bit;
                        end
                    end
                    default: begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            last_q  <= 1'b1;
            run_q   <= 3'd0;
            total_q <= 8'd0;
            stuff_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            last_q  <= last_d;
            run_q   <= run_d;
            total_q <= total_d;
            stuff_q <= stuff_d;
        end
    end

    assign stall          = (state_q == S_STUFF);
    assign tx_bit_stuffed = tx_q;
    assign stuff_inserted = stuff_q;
    assign stuff_total    = total_q;

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Randomized and directed bench for can_bit_stuffer; expected bus streams come
// from a bit-level model of the CAN stuffing rule.
module tb_can_bit_stuffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_point = 1'b0;
    logic       frame_active = 1'b0;
    logic       stuff_en = 1'b0;
    logic       in_bit = 1'b1;
    logic       arbitration_active = 1'b0;
    logic       ack_slot = 1'b0;
    logic       rx_bit = 1'b1;
    logic       tx_bit_stuffed, stall, stuff_inserted, arb_lost, bit_error, ack_seen;
    logic [7:0] stuff_total;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic stall_at;
    bit   frame_q[$];

    always #5 clk = ~clk;

    can_bit_stuffer dut (
        .clk                (clk),
        .rst                (rst),
        .sample_point       (sample_point),
        .frame_active       (frame_active),
        .stuff_en           (stuff_en),
        .in_bit             (in_bit),
        .arbitration_active (arbitration_active),
        .ack_slot           (ack_slot),
        .rx_bit             (rx_bit),
        .tx_bit_stuffed     (tx_bit_stuffed),
        .stall              (stall),
        .stuff_inserted     (stuff_inserted),
        .arb_lost           (arb_lost),
        .bit_error          (bit_error),
        .ack_seen           (ack_seen),
        .stuff_total        (stuff_total)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Idle clocks, then one sample_point cycle; outputs settle #1 after its edge.
    task automatic do_sample(input bit loopback, input logic rxv);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rx_bit       = loopback ? tx_bit_stuffed : rxv;
        stall_at     = stall;
        sample_point = 1'b1;
        @(posedge clk);
        #1;
        sample_point = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        frame_active = 1'b0; stuff_en = 1'b0; in_bit = 1'b1;
        arbitration_active = 1'b0; ack_slot = 1'b0; rx_bit = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tx", tx_bit_stuffed, 1);
        chk("rst_stall", stall, 0);
        chk("rst_total", stuff_total, 0);
        chk("rst_pulses", {stuff_inserted, arb_lost, bit_error, ack_seen}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_bits(input logic [63:0] v, input int n);
        frame_q.delete();
        for (int i = n - 1; i >= 0; i--) frame_q.push_back(v[i]);
    endtask

    // Plays frame_q as the transmitter would, stuffing region = first r bits.
    task automatic run_frame(input int r);
        bit out[$];
        bit isst[$];
        int run, nst, idx;
        bit b;
        run = 0; nst = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            b = frame_q[i];
            run = (out.size() > 0 && out[out.size()-1] == b) ? run + 1 : 1;
            out.push_back(b); isst.push_back(1'b0);
            if (i < r && run == 5) begin
                out.push_back(!b); isst.push_back(1'b1);
                nst++; run = 1;
            end
        end
        idx = 0;
        arbitration_active = 1'b0; ack_slot = 1'b0;
        for (int j = 0; j <= out.size(); j++) begin
            frame_active = (idx < frame_q.size());
            in_bit       = frame_active ? frame_q[idx] : 1'b1;
            stuff_en     = (idx < r);
            do_sample(1'b1, 1'b1);
            chk("tx", tx_bit_stuffed, (j < out.size()) ? 32'(out[j]) : 32'd1);
            chk("stuff_pulse", stuff_inserted, (j < out.size()) ? 32'(isst[j]) : 32'd0);
            chk("stall", stall, (j + 1 < out.size()) ? 32'(isst[j+1]) : 32'd0);
            chk("no_err", {arb_lost, bit_error, ack_seen}, 0);
            if (!stall_at && idx < frame_q.size()) idx++;
        end
        frame_active = 1'b0;
        chk("frame_total", stuff_total, nst);
        chk("consumed", idx, frame_q.size());
    endtask

    initial begin
        int  seen;
        bit  hit, b;
        int  len;
        do_reset();

        // Six dominant bits from SOF, then recessive/dominant: one stuff.
        load_bits(64'b00000001, 8);
        run_frame(8);
        chk("sof_zeros_total", stuff_total, 1);

        // 00000 1111: stuff 1, then stuff bit + 1111 forces a 0 stuff.
        load_bits(64'b0000011110, 10);
        run_frame(10);
        chk("chain_total", stuff_total, 2);

        // Eleven 1s, stuffing region only three bits long.
        load_bits(64'h7FF, 11);
        run_frame(3);
        chk("tail_total", stuff_total, 0);

        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(6, 30);
            frame_q.delete();
            b = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) b = !b;
                frame_q.push_back(b);
            end
            run_frame($urandom_range(1, len));
        end

        // Lost arbitration: recessive driven, dominant read.
        do_reset();
        frame_active = 1'b1; stuff_en = 1'b1; in_bit = 1'b1;
        do_sample(1'b0, 1'b1);
        arbitration_active = 1'b1;
        do_sample(1'b0, 1'b0);
        chk("arb_lost", arb_lost, 1);
        chk("arb_no_err", bit_error, 0);
        chk("arb_tx", tx_bit_stuffed, 1);
        frame_active = 1'b0; arbitration_active = 1'b0;
        do_sample(1'b0, 1'b0);
        chk("arb_idle_quiet", {arb_lost, bit_error}, 0);
        chk("arb_idle_tx", tx_bit_stuffed, 1);

        // ACK slot dominant is fine; a data mismatch afterwards is a bit error.
        do_reset();
        frame_active = 1'b1; stuff_en = 1'b0; in_bit = 1'b1;
        do_sample(1'b0, 1'b1);
        ack_slot = 1'b1; in_bit = 1'b0;
        do_sample(1'b0, 1'b0);
        chk("ack_seen", ack_seen, 1);
        chk("ack_no_err", bit_error, 0);
        chk("ack_tx", tx_bit_stuffed, 0);
        ack_slot = 1'b0;
        do_sample(1'b0, 1'b1);
        chk("data_bit_err", bit_error, 1);
        chk("data_err_tx", tx_bit_stuffed, 1);
        @(posedge clk);
        #1;
        chk("err_pulse_clear", bit_error, 0);
        frame_active = 1'b0;

        // Reset while the second stuff bit is pending.
        do_reset();
        load_bits(64'b00000111100, 11);
        seen = 0; hit = 1'b0;
        for (int k = 0, idx = 0; k < 20 && !hit; k++) begin
            frame_active = 1'b1; stuff_en = 1'b1; in_bit = frame_q[idx];
            do_sample(1'b1, 1'b1);
            if (!stall_at && idx < frame_q.size() - 1) idx++;
            if (stall) begin
                seen++;
                if (seen == 2) hit = 1'b1;
            end
        end
        chk("stuff_reached", hit, 1);
        chk("pre_rst_total", stuff_total, 1);
        @(negedge clk);
        rst = 1'b1; frame_active = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_stall_drop", stall, 0);
        chk("rst_stuff_tx", tx_bit_stuffed, 1);
        chk("rst_stuff_total", stuff_total, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/can_bit_stuffer.md
CAN_BIT_STUFFER -- requirements
Module: can_bit_stuffer

Interface
REQ-001 SHALL expose: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL expose: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: sample_point  input  1  one-cycle bit-time strobe, shared with transmitter.
REQ-004 SHALL expose: frame_active  input  1  transmitter is sending a frame (SOF through IFS).
REQ-005 SHALL expose: stuff_en  input  1  stuffing region (SOF through last CRC bit).
REQ-006 SHALL expose: in_bit  input  1  unstuffed bit from transmitter's registered tx_bit.
REQ-007 SHALL expose: arbitration_active  input  1  arbitration field in progress.
REQ-008 SHALL expose: ack_slot  input  1  current driven bit is the ACK slot.
REQ-009 SHALL expose: rx_bit  input  1  bus level read back at sample_point.
REQ-010 SHALL expose: tx_bit_stuffed  output  1  bus drive bit, 1 = recessive.
REQ-011 SHALL expose: stall  output  1  combinational; transmitter advances only on sample_point & ~stall.
REQ-012 SHALL expose: stuff_inserted  output  1  one-cycle pulse per stuff bit driven.
REQ-013 SHALL expose: arb_lost, bit_error, ack_seen  output  1 each  one-cycle pulses.
REQ-014 SHALL expose: stuff_total  output  8  stuff bits in current frame, saturating at 255.

Function
REQ-015 All state SHALL update only when sample_point=1; otherwise it holds.
REQ-016 FSM states SHALL be S_IDLE, S_PASS, S_STUFF, S_TAIL.
REQ-017 S_IDLE: tx_bit_stuffed registers 1; on frame_active=1 register in_bit, set last_bit=in_bit, run_cnt=1, stuff_total=0, go S_PASS.
REQ-018 S_PASS: tx_bit_stuffed <= in_bit; run_cnt increments if in_bit==last_bit, else run_cnt=1 and last_bit=in_bit.
REQ-019 run_cnt SHALL be 3 bits; reaching 5 with stuff_en=1 SHALL move to S_STUFF.
REQ-020 stall SHALL be 1 exactly while state==S_STUFF, so the transmitter holds in_bit for that bit time.
REQ-021 S_STUFF: tx_bit_stuffed <= ~last_bit; last_bit <= ~last_bit; run_cnt=1; stuff_inserted pulses; stuff_total increments; return to S_PASS.
REQ-022 A stuff bit SHALL count toward the next run (stuff bit plus four equal data bits triggers another stuff).
REQ-023 stuff_en=0 in S_PASS SHALL move to S_TAIL: pass-through, no counting, no stalls; frame_active=0 in S_PASS/S_TAIL returns to S_IDLE.
REQ-024 Latency in_bit to tx_bit_stuffed SHALL be one sample_point.
REQ-025 Monitor at each sample_point outside S_IDLE compares rx_bit with current tx_bit_stuffed.
REQ-026 Sent 1, read 0, arbitration_active=1: arb_lost pulses; state -> S_IDLE; tx_bit_stuffed <= 1.
REQ-027 Sent 1, read 0, ack_slot=1: ack_seen pulses, no error.
REQ-028 Any other mismatch: bit_error pulses; state -> S_IDLE; tx_bit_stuffed <= 1.
REQ-029 Monitor events SHALL take priority over stuffing decisions in the same sample_point.

Reset
REQ-030 rst=1 SHALL, on the clock edge regardless of sample_point, force S_IDLE, tx_bit_stuffed=1, run_cnt=0, last_bit=1, stuff_total=0, and all pulses to 0.
REQ-031 Reset mid-frame, including during S_STUFF, SHALL drop stall in the following cycle.

Structure
REQ-032 The state enum and STUFF_RUN_LEN=5 SHALL live in the shared can_defs package.
REQ-033 The bit monitor SHALL be a sub-module can_bit_monitor (combinational compare with registered pulses).

Verification
REQ-034 ID 0x000, DLC 0: SOF plus five 0s -> 1 stuffed after the fifth 0, stall high one bit time, stuff_inserted=1.
REQ-035 Pattern 00000 1111 -> stuff 1 after the 0s, then the stuff bit plus 1111 triggers a 0 stuff; stuff_total=2.
REQ-036 Eleven 1s with stuff_en dropped after bit 3 -> no stuff bits, stall never asserted.
REQ-037 Drive 1 in arbitration with rx_bit=0 -> arb_lost pulse, tx_bit_stuffed=1, state S_IDLE.
REQ-038 ACK slot with rx_bit=0 -> ack_seen, no bit_error; a data-field mismatch -> bit_error.
REQ-039 Assert rst during S_STUFF -> next cycle stall=0, tx_bit_stuffed=1, stuff_total=0.
